// File: rtl/gpu_bus_driver_if.sv
// Request handshake plus 6502-style write bus of the GPU bus driver.
// master: the driver side; slave: the host/requester side.
`timescale 1ns/1ps
interface gpu_bus_driver_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_addr;
    logic [7:0] req_data;
    logic       busy;
    logic       done;
    logic       cpu_clk;
    logic       cs;
    logic       rw;
    logic [2:0] addr;
    logic [7:0] data;

    modport master (
        input  req_valid, req_addr, req_data,
        output req_ready, busy, done,
        output cpu_clk, cs, rw, addr, data
    );

    modport slave (
        output req_valid, req_addr, req_data,
        input  req_ready, busy, done,
        input  cpu_clk, cs, rw, addr, data
    );
endinterface

// File: rtl/gpu_bus_driver.sv
// Replays queued register writes as 6502-style bus cycles (cpu_clk/cs/rw/addr/data).
// Ports: clk, rst (async, active-high), bus (gpu_bus_driver_if.master). Macro: GPU_BUS_DRV_FIFO_EN.
`timescale 1ns/1ps
module gpu_bus_driver #(
    parameter int HALF_PERIOD = 25,
    parameter int FIFO_AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    gpu_bus_driver_if.master  bus
);
    localparam int            CW   = $clog2(HALF_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_cpu_clk;
    logic          w_wrap;
    logic          w_fe;

    logic          r_cs;
    logic          r_rw;
    logic          r_done;
    logic [2:0]    r_addr;
    logic [7:0]    r_data;
    logic          w_cs_nxt;
    logic          w_rw_nxt;
    logic          w_done_nxt;
    logic [2:0]    w_addr_nxt;
    logic [7:0]    w_data_nxt;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [10:0]   w_head;

    assign w_wrap = (r_cnt == LAST);
    // Falling edge of cpu_clk: the GPU samples here, so the bus changes here.
    assign w_fe   = w_wrap && r_cpu_clk;
    // Full is judged before any pop in the same clk.
    assign w_push = bus.req_valid && !w_full;
    assign w_pop  = w_fe && !w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_cpu_clk <= 1'b0;
        end else if (w_wrap) begin
            r_cnt     <= '0;
            r_cpu_clk <= ~r_cpu_clk;
        end else begin
            r_cnt     <= r_cnt + 1'b1;
        end
    end

`ifdef GPU_BUS_DRV_FIFO_EN
    localparam int DEPTH = 1 << FIFO_AW;

    logic [10:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (FIFO_AW+1)'(DEPTH));
    assign w_head  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {bus.req_addr, bus.req_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (FIFO_AW+1)'(w_push) - (FIFO_AW+1)'(w_pop);
        end
    end
`else
    logic        r_hold_valid;
    logic [10:0] r_hold;

    assign w_empty = !r_hold_valid;
    assign w_full  = r_hold_valid;
    assign w_head  = r_hold;

    // Push needs an empty register and pop a full one, so they never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
            r_hold       <= '0;
        end else if (w_push) begin
            r_hold_valid <= 1'b1;
            r_hold       <= {bus.req_addr, bus.req_data};
        end else if (w_pop) begin
            r_hold_valid <= 1'b0;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cs_nxt    = r_cs;
        w_rw_nxt    = r_rw;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        if (w_fe) begin
            w_done_nxt = (r_state == ACTIVE);
            if (!w_empty) begin
                w_state_nxt = ACTIVE;
                w_cs_nxt    = 1'b1;
                w_rw_nxt    = 1'b0;
                w_addr_nxt  = w_head[10:8];
                w_data_nxt  = w_head[7:0];
            end else begin
                w_state_nxt = IDLE;
                w_cs_nxt    = 1'b0;
                w_rw_nxt    = 1'b1;
                w_addr_nxt  = '0;
                w_data_nxt  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cs    <= 1'b0;
            r_rw    <= 1'b1;
            r_addr  <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cs    <= w_cs_nxt;
            r_rw    <= w_rw_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.req_ready = !w_full;
    assign bus.busy      = (r_state == ACTIVE) || !w_empty;
    assign bus.done      = r_done;
    assign bus.cpu_clk   = r_cpu_clk;
    assign bus.cs        = r_cs;
    assign bus.rw        = r_rw;
    assign bus.addr      = r_addr;
    assign bus.data      = r_data;
endmodule

// File: tb/tb_gpu_bus_driver.sv
// Self-checking bench for gpu_bus_driver: directed vector table, corner sequences,
// and random traffic against a queue-based timing model.
`timescale 1ns/1ps
module tb_gpu_bus_driver;
    localparam int HP  = 2;
    localparam int FAW = 2;
`ifdef GPU_BUS_DRV_FIFO_EN
    localparam int CAP = 1 << FAW;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gpu_bus_driver_if bus_if();

    gpu_bus_driver #(.HALF_PERIOD(HP), .FIFO_AW(FAW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: edge count since reset release, pending queue, current bus word.
    int          m_n;
    logic [10:0] m_q[$];
    bit          m_act;
    logic [2:0]  m_addr;
    logic [7:0]  m_data;
    bit          m_done;

    typedef struct {
        bit         v;
        logic [2:0] a;
        logic [7:0] d;
        bit         cpu;
        bit         cs;
        bit         rw;
        logic [2:0] ea;
        logic [7:0] ed;
        bit         done;
        bit         busy;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] act_vec();
        return {bus_if.req_ready, bus_if.busy, bus_if.done, bus_if.cpu_clk,
                bus_if.cs, bus_if.rw, bus_if.addr, bus_if.data};
    endfunction

    function automatic logic [16:0] exp_vec();
        bit rdy, bsy, cpu;
        rdy = (m_q.size() < CAP);
        bsy = m_act || (m_q.size() != 0);
        cpu = ((m_n / HP) % 2) == 1;
        return {rdy, bsy, m_done, cpu, m_act, !m_act, m_addr, m_data};
    endfunction

    task automatic model_reset();
        m_n = 0;
        m_q.delete();
        m_act = 0;
        m_addr = '0;
        m_data = '0;
        m_done = 0;
    endtask

    task automatic model_edge();
        bit rdy;
        rdy = (m_q.size() < CAP);
        m_n++;
        m_done = 0;
        if (m_n % (2 * HP) == 0) begin
            if (m_act) m_done = 1;
            if (m_q.size() > 0) begin
                {m_addr, m_data} = m_q.pop_front();
                m_act = 1;
            end else begin
                m_act = 0;
                m_addr = '0;
                m_data = '0;
            end
        end
        if (bus_if.req_valid && rdy) m_q.push_back({bus_if.req_addr, bus_if.req_data});
    endtask

    task automatic step(input bit cmp);
        @(posedge clk);
        model_edge();
        #1;
        if (cmp) chk("model", 32'(act_vec()), 32'(exp_vec()));
    endtask

    task automatic apply_reset();
        bus_if.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        chk("reset_state", 32'(act_vec()),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'd0}));
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic seq_table();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            bus_if.req_valid = tbl[i].v;
            bus_if.req_addr  = tbl[i].a;
            bus_if.req_data  = tbl[i].d;
            step(0);
            chk($sformatf("vec%0d", i),
                32'({bus_if.cpu_clk, bus_if.cs, bus_if.rw, bus_if.addr,
                     bus_if.data, bus_if.done, bus_if.busy}),
                32'({tbl[i].cpu, tbl[i].cs, tbl[i].rw, tbl[i].ea,
                     tbl[i].ed, tbl[i].done, tbl[i].busy}));
        end
    endtask

    task automatic seq_b2b();
        logic [10:0] rq[3];
        logic [10:0] got[$];
        int idx, dn, gap, last, bad;
        bit span, pcs, acc;
        rq[0] = {3'd5, 8'h11};
        rq[1] = {3'd2, 8'h22};
        rq[2] = {3'd7, 8'h33};
        idx = 0; dn = 0; gap = 0; last = -1; bad = 0; span = 0; pcs = 0;
        apply_reset();
        for (int e = 1; e <= 40 && dn < 3; e++) begin
            if (idx < 3) begin
                bus_if.req_valid = 1'b1;
                {bus_if.req_addr, bus_if.req_data} = rq[idx];
            end else begin
                bus_if.req_valid = 1'b0;
            end
            acc = bus_if.req_valid && bus_if.req_ready;
            step(1);
            if (acc) idx++;
            if (bus_if.cs && (!pcs || bus_if.done)) got.push_back({bus_if.addr, bus_if.data});
            if (bus_if.cs) span = 1;
            if (bus_if.done) begin
                dn++;
                if (last >= 0 && e - last != 2 * HP) bad++;
                last = e;
            end
            if (span && dn < 3 && !bus_if.cs) gap++;
            pcs = bus_if.cs;
        end
        bus_if.req_valid = 1'b0;
        chk("b2b_done_count", dn, 3);
        chk("b2b_cs_gap", gap, 0);
        chk("b2b_done_spacing", bad, 0);
        chk("b2b_got_count", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            chk($sformatf("b2b_order%0d", i), 32'(got[i]), 32'(rq[i]));
    endtask

    task automatic seq_mid_reset();
        bit hit;
        int cs_hi;
        hit = 0;
        cs_hi = 0;
        apply_reset();
        for (int i = 0; i < 40 && !hit; i++) begin
            bus_if.req_valid = 1'b1;
            bus_if.req_addr  = i[2:0];
            bus_if.req_data  = 8'h40 + i[7:0];
            step(1);
            if (bus_if.cs && m_q.size() >= ((CAP > 1) ? 2 : 1)) hit = 1;
        end
        bus_if.req_valid = 1'b0;
        chk("rst_setup", hit, 1);
        for (int i = 0; i < 4 && !bus_if.cpu_clk; i++) step(1);
        chk("rst_setup_clk_high", {bus_if.cpu_clk, bus_if.cs}, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", {bus_if.cs, bus_if.rw, bus_if.cpu_clk, bus_if.busy,
                          bus_if.done, bus_if.req_ready}, 6'b010001);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step(1);
            if (bus_if.cs) cs_hi++;
        end
        chk("post_rst_cs_high", cs_hi, 0);
        chk("post_rst_busy", bus_if.busy, 0);
    endtask

    task automatic seq_idle();
        int tog, dn, cs_hi;
        bit pclk;
        tog = 0; dn = 0; cs_hi = 0;
        apply_reset();
        pclk = bus_if.cpu_clk;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (bus_if.cpu_clk != pclk) tog++;
            if (bus_if.done) dn++;
            if (bus_if.cs) cs_hi++;
            pclk = bus_if.cpu_clk;
        end
        chk("idle_toggles", tog, 100 / HP);
        chk("idle_done", dn, 0);
        chk("idle_cs", cs_hi, 0);
    endtask

    task automatic seq_random();
        int pct;
        apply_reset();
        for (int blk = 0; blk < 6; blk++) begin
            pct = $urandom_range(90, 10);
            if (blk == 3) apply_reset();
            for (int k = 0; k < 150; k++) begin
                bus_if.req_valid = ($urandom_range(99, 0) < pct);
                bus_if.req_addr  = 3'($urandom);
                bus_if.req_data  = 8'($urandom);
                step(1);
            end
        end
        bus_if.req_valid = 1'b0;
        for (int i = 0; i < 8 * (CAP + 1) * HP; i++) step(1);
        chk("drained_busy", bus_if.busy, 0);
    endtask

    initial begin
        bus_if.req_valid = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_data  = '0;
        model_reset();
        //         v  a  d      cpu cs rw ea ed     done busy
        tbl[0] = '{1, 3, 8'hA5, 0,  0, 1, 0, 8'h00, 0,   1};
        tbl[1] = '{0, 0, 8'h00, 1,  0, 1, 0, 8'h00, 0,   1};
        tbl[2] = '{0, 0, 8'h00, 1,  0, 1, 0, 8'h00, 0,   1};
        tbl[3] = '{0, 0, 8'h00, 0,  1, 0, 3, 8'hA5, 0,   1};
        tbl[4] = '{0, 0, 8'h00, 0,  1, 0, 3, 8'hA5, 0,   1};
        tbl[5] = '{0, 0, 8'h00, 1,  1, 0, 3, 8'hA5, 0,   1};
        tbl[6] = '{0, 0, 8'h00, 1,  1, 0, 3, 8'hA5, 0,   1};
        tbl[7] = '{0, 0, 8'h00, 0,  0, 1, 0, 8'h00, 1,   0};
        tbl[8] = '{0, 0, 8'h00, 0,  0, 1, 0, 8'h00, 0,   0};
        tbl[9] = '{0, 0, 8'h00, 1,  0, 1, 0, 8'h00, 0,   0};
        repeat (2) @(posedge clk);
        seq_table();
        seq_b2b();
        seq_mid_reset();
        seq_idle();
        seq_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/gpu_bus_driver.md
# gpu_bus_driver

Bus initiator for the GPU's CPU-side register port: it takes 8-bit write requests (3-bit register index + data) over a valid/ready handshake and replays them as 6502-style bus cycles on cpu_clk/cs/rw/addr/data. It sits between a host-side source (bring-up sequencer, boot loader, soft CPU stub) and the GPU's `bus_interface`, and emits exactly the bus activity that block consumes. Writes only; rw is never driven high during a cycle.

## Interface
- HALF_PERIOD, 25, clk cycles per cpu_clk phase (cpu_clk period = 2*HALF_PERIOD; 25 gives 2 MHz from 100 MHz); legal ≥ 2.
- FIFO_AW, 4, request FIFO address width (depth 2**FIFO_AW); used only with GPU_BUS_DRV_FIFO_EN.

- clk  in  1  system clock (100 MHz domain).
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_addr  in  3  GPU register index.
- req_data  in  8  write data.
- busy  out  1  cycle on bus or request pending.
- done  out  1  one-clk pulse when a bus cycle completes.
- cpu_clk  out  1  free-running bus clock (phi2).
- cs  out  1  chip select, active-high.
- rw  out  1  1 = read/idle, 0 = write.
- addr  out  3  register index on bus.
- data  out  8  write data on bus.

## Operation
- Phase counter cnt counts 0..HALF_PERIOD-1; at cnt == HALF_PERIOD-1, cnt wraps to 0 and cpu_clk toggles. cpu_clk runs continuously, regardless of traffic.
- Falling-edge event fe = (cnt == HALF_PERIOD-1) && cpu_clk == 1.
- Request accepted on clk edge where req_valid && req_ready; stored in pending storage.
- States: IDLE, ACTIVE.
  - IDLE: cs=0, rw=1, addr=0, data=0. At fe with pending non-empty: pop head, load addr/data, cs=1, rw=0 → ACTIVE (bus signals change on same edge cpu_clk goes low).
  - ACTIVE: bus held stable through low and high phases. At next fe: done=1 for one clk; if pending non-empty, pop and load next request (cs stays 1, back-to-back) and remain ACTIVE; else cs=0, rw=1, addr=0, data=0 → IDLE.
- GPU samples on cpu_clk falling edge: addr/data/cs/rw are stable one full period around it.
- busy = (state == ACTIVE) || pending non-empty.
- Push and pop in the same clk: both happen; req_ready is computed from occupancy before the pop (full ⇒ push refused even if popping).
- Reset (any time, including mid-cycle): all state cleared asynchronously, pending requests discarded, no done pulse.

## Timing
- Reset values: cnt=0, cpu_clk=0, cs=0, rw=1, addr=0, data=0, done=0, busy=0, req_ready=1, pending empty.
- After reset release: first cpu_clk rise at clk edge HALF_PERIOD, first fe-driven fall at edge 2*HALF_PERIOD.
- Issue latency: request accepted at edge t appears on bus at the first fe strictly after t (1 .. 2*HALF_PERIOD clks).
- Cycle length: exactly 2*HALF_PERIOD clks; done asserted on the edge that ends it.
- Sustained throughput: one write per cpu_clk period when pending never empties.

## Configuration
- GPU_BUS_DRV_FIFO_EN defined: pending storage is a 2**FIFO_AW-entry FIFO (registered, no fall-through); req_ready = !full.
- Undefined: pending storage is a single holding register; req_ready = !holding_valid. Back-to-back cycles still possible (holding register refills during ACTIVE). FIFO_AW ignored.

## Test plan
- HALF_PERIOD=2, reset, one request addr=3 data=0xA5 at edge 1 → at edge 4 cpu_clk falls, cs=1 rw=0 addr=3 data=0xA5; held until edge 8, done pulse at edge 8, then cs=0 rw=1 addr=0 data=0.
- Three requests pushed in consecutive clks (FIFO_EN) → three contiguous bus cycles, cs never drops, three done pulses 4 clks apart, order preserved.
- FIFO_AW=2, 6 pushes with bus stalled behind cycle → req_ready falls after 4 queued entries; push on full refused even on pop cycle; no data lost or duplicated.
- Without GPU_BUS_DRV_FIFO_EN: second request while holding full → req_ready=0 until holding popped at fe; both writes appear in order.
- rst asserted mid-ACTIVE with 2 queued → cs=0, rw=1, cpu_clk=0 immediately; after release no further bus cycles, busy=0.
- No requests for 100 clks → cpu_clk toggles every HALF_PERIOD clks, cs stays 0, done never pulses.
